est_dr_fifo_nack_clk: RTL and testbench
=======================================

Name: est_dr_fifo_nack_clk

Overview:
Clocked, parametrised successor to the single-bit dual-rail 5-ack buffer stage. It accepts W-bit dual-rail words over a 4-phase return-to-zero handshake and stores up to DEPTH words. It broadcasts each word to N_ACK consumers and waits on a C-element-style join of all their acks. It is used where the asynchronous datapath meets clocked logic, and carries an optional reset token like the set-type stage.

Parameters:
W, 1, dual-rail word width in logical bits (ports are 2*W wide)
DEPTH, 2, storage entries (>=1)
N_ACK, 4, number of consumer ack inputs joined
RESET_TOKEN, 1, 1 = output presents RESET_VAL after reset; 0 = output starts NULL
RESET_VAL, 1, W-bit logical value of reset token (bit i = 1 -> true rail)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
data_in  in  2*W  dual-rail input; bit i: [2i+1] true rail, [2i] false rail
ack  out  1  acknowledge to producer
data_out  out  2*W  dual-rail output, same encoding
ack_in  in  N_ACK  consumer acks, active high
count  out  clog2(DEPTH+1)  stored entries, excluding the output register
err  out  1  sticky illegal-code flag

Behaviour:
- Input decode (combinational on data_in):
  - complete = every bit has exactly one rail high.
  - null = all rails 0.
  - illegal = any bit with both rails high.
- Input FSM:
  - I_DATA (ack=0): if complete and count<DEPTH, write word at edge, go to I_NULL. If complete and full, hold and keep ack=0 until a slot frees. Partial words are ignored.
  - I_NULL (ack=1): if null, go to I_DATA. Ack drops the cycle after null is sampled.
  - ack is registered; it rises one cycle after the capturing edge.
- Illegal code in any state: err set at the next edge, word not written, FSM state unchanged. err clears only on reset.
- Storage: circular buffer, wr_ptr/rd_ptr wrap at DEPTH-1 -> 0.
  - count +1 on write, -1 on pop, unchanged on simultaneous write and pop.
  - Write into a full buffer is impossible by the I_DATA rule.
  - A pop and a write in the same cycle when count==DEPTH is allowed: the freed slot is refilled on the following edge, not the same one.
- Output FSM (data_out registered):
  - O_NULL (data_out all 0): when all ack_in==0 and count>0, pop head into the output register, go to O_DATA. data_out is valid the cycle after the pop edge.
  - O_DATA (data_out = word): when all ack_in==1, go to O_NULL and zero data_out at that edge.
  - Mixed acks: hold current state and value (C-element join).
  - O_NULL with count==0: hold NULL.
- Latency, empty buffer:
  - Input complete sampled at edge t -> word written at t -> data_out valid at t+1 (only if all ack_in were already 0 at t+1).
  - ack rises at t+1.
- Reset (async, any time, including mid-handshake): ptrs=0, count=0, err=0, ack=0, input FSM = I_DATA.
  - RESET_TOKEN=1: output FSM = O_DATA, data_out = dual-rail(RESET_VAL).
  - RESET_TOKEN=0: output FSM = O_NULL, data_out = 0.
  - Any in-flight word is discarded.
- Release with producer still driving a complete word: accepted as a fresh word on the first edge after release.

Test Plan:
- Reset token: W=2, RESET_VAL=2'b01, rst_n low -> data_out=4'b0110, ack=0, count=0. Drive ack_in=4'hF -> data_out=0 the next cycle.
- Single word: empty buffer, ack_in=0, data_in=4'b1001 (value 2'b10) -> ack=1 and data_out=4'b1001 one cycle after capture. data_in=0 -> ack=0 next cycle.
- Join: data_out valid, ack_in=4'b0111 for 5 cycles -> data_out held. ack_in=4'hF -> NULL next cycle. ack_in=4'b1000 -> no pop despite count=1.
- Full/back-pressure: DEPTH=2, ack_in held 4'hF, push 3 words -> third word sees ack stay 0 with count=2. Release acks -> third word accepted. All words emerge in order, with pointer wrap verified.
- Illegal code: data_in=4'b0011 -> err=1 next edge, count unchanged, ack=0. Later legal traffic works and err stays 1.
- Reset mid-operation: count=2, data_out valid, ack=1; pulse rst_n low asynchronously between edges -> all outputs at reset values immediately, count=0.

Source files
------------

// File: rtl/est_dr_fifo_nack_clk.sv
// Dual-rail 4-phase FIFO stage broadcasting each word to N_ACK consumers behind a C-element ack join.
// Latency: capture at edge t, ack and data_out at t+1; when full, ack stays low until a slot frees.
module est_dr_fifo_nack_clk #(
  parameter int             W           = 1,
  parameter int             DEPTH       = 2,
  parameter int             N_ACK       = 4,
  parameter bit             RESET_TOKEN = 1'b1,
  parameter logic [W-1:0]   RESET_VAL   = W'(1)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [2*W-1:0]               data_in,
  output logic                         ack,
  output logic [2*W-1:0]               data_out,
  input  logic [N_ACK-1:0]             ack_in,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         err
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic {I_DATA, I_NULL} in_state_t;
  typedef enum logic {O_NULL, O_DATA} out_state_t;

  function automatic logic [2*W-1:0] to_dual_rail(input logic [W-1:0] v);
    logic [2*W-1:0] r;
    for (int i = 0; i < W; i++) begin
      r[2*i+1] = v[i];
      r[2*i]   = ~v[i];
    end
    return r;
  endfunction

  localparam logic [2*W-1:0] RESET_WORD = RESET_TOKEN ? to_dual_rail(RESET_VAL) : '0;

  in_state_t        in_state;
  out_state_t       out_state;
  logic [2*W-1:0]   mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             in_complete;
  logic             in_null;
  logic             in_illegal;
  logic             do_write;
  logic             do_pop;

  always_comb begin
    in_complete = 1'b1;
    in_illegal  = 1'b0;
    for (int i = 0; i < W; i++) begin
      in_complete = in_complete & (data_in[2*i+1] ^ data_in[2*i]);
      in_illegal  = in_illegal | (data_in[2*i+1] & data_in[2*i]);
    end
  end

  assign in_null = (data_in == '0);

  // Full check uses the registered count, so a slot freed by a pop is refilled one edge later.
  assign do_write = (in_state == I_DATA) && in_complete && (count < FULL);
  assign do_pop   = (out_state == O_NULL) && (ack_in == '0) && (count != '0);

  always_ff @(posedge clk) begin
    if (do_write) mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_state  <= I_DATA;
      ack       <= 1'b0;
      err       <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_state <= RESET_TOKEN ? O_DATA : O_NULL;
      data_out  <= RESET_WORD;
    end else begin
      ack <= (in_state == I_NULL);
      err <= err | in_illegal;

      case (in_state)
        I_DATA:  if (do_write) in_state <= I_NULL;
        I_NULL:  if (in_null) in_state <= I_DATA;
        default: in_state <= I_DATA;
      endcase

      // Mixed consumer acks leave the output untouched in either state.
      case (out_state)
        O_NULL: begin
          if (do_pop) begin
            data_out  <= mem[rd_ptr];
            out_state <= O_DATA;
          end
        end
        O_DATA: begin
          if (&ack_in) begin
            data_out  <= '0;
            out_state <= O_NULL;
          end
        end
        default: out_state <= O_NULL;
      endcase

      if (do_write) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      if (do_pop)   rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;

      if (do_write && !do_pop)      count <= count + 1'b1;
      else if (!do_write && do_pop) count <= count - 1'b1;
    end
  end
endmodule

// File: tb/tb_est_dr_fifo_nack_clk.sv
// Bench for est_dr_fifo_nack_clk: directed handshake scenarios then random producer/consumer traffic.
// Every cycle the outputs are compared with a queue-based model of the stage.
module tb_est_dr_fifo_nack_clk;
  localparam int             W           = 2;
  localparam int             DEPTH       = 2;
  localparam int             N_ACK       = 4;
  localparam bit             RESET_TOKEN = 1'b1;
  localparam logic [W-1:0]   RESET_VAL   = 2'b01;
  localparam int             CW          = $clog2(DEPTH + 1);
  localparam logic [2*W-1:0] LOW_MASK    = 4'b0011;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [2*W-1:0]       data_in = '0;
  logic                 ack;
  logic [2*W-1:0]       data_out;
  logic [N_ACK-1:0]     ack_in = '0;
  logic [CW-1:0]        count;
  logic                 err;

  always #5 clk = ~clk;

  est_dr_fifo_nack_clk #(
    .W(W), .DEPTH(DEPTH), .N_ACK(N_ACK), .RESET_TOKEN(RESET_TOKEN), .RESET_VAL(RESET_VAL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .ack(ack),
    .data_out(data_out), .ack_in(ack_in), .count(count), .err(err)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: stored logical values in a queue, output word plus a valid flag.
  logic [W-1:0] m_q[$];
  bit           m_in_wait;
  bit           m_ack;
  bit           m_err;
  bit           m_out_vld;
  logic [W-1:0] m_out;

  function automatic logic [2*W-1:0] dr(input logic [W-1:0] v);
    logic [2*W-1:0] r;
    for (int i = 0; i < W; i++) begin
      r[2*i+1] = v[i];
      r[2*i]   = ~v[i];
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_in_wait = 1'b0;
    m_ack     = 1'b0;
    m_err     = 1'b0;
    m_out_vld = RESET_TOKEN;
    m_out     = RESET_VAL;
  endtask

  task automatic model_step();
    bit           cmp;
    bit           ill;
    bit           nul;
    bit           wr;
    bit           pop;
    logic [W-1:0] v;
    cmp = 1'b1;
    ill = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (data_in[2*i+1] == data_in[2*i]) cmp = 1'b0;
      if (data_in[2*i+1] && data_in[2*i]) ill = 1'b1;
      v[i] = data_in[2*i+1];
    end
    nul = (data_in == '0);
    wr  = !m_in_wait && cmp && (m_q.size() < DEPTH);
    pop = !m_out_vld && (ack_in == '0) && (m_q.size() > 0);
    m_ack = m_in_wait;
    if (wr) m_in_wait = 1'b1;
    else if (m_in_wait && nul) m_in_wait = 1'b0;
    if (ill) m_err = 1'b1;
    if (pop) begin
      m_out     = m_q.pop_front();
      m_out_vld = 1'b1;
    end else if (m_out_vld && (&ack_in)) begin
      m_out_vld = 1'b0;
    end
    if (wr) m_q.push_back(v);
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".data_out"}, data_out, m_out_vld ? dr(m_out) : '0);
    chk({tag, ".ack"}, ack, m_ack);
    chk({tag, ".count"}, count, m_q.size());
    chk({tag, ".err"}, err, m_err);
  endtask

  // One clock: model advances on the edge, DUT is compared on the following falling edge.
  task automatic cycle(input string tag);
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic push(input logic [W-1:0] v, input string tag);
    data_in = dr(v);
    for (int i = 0; i < 20 && ack !== 1'b1; i++) cycle(tag);
    chk({tag, ".ack_hi"}, ack, 1);
    data_in = '0;
    for (int i = 0; i < 20 && ack !== 1'b0; i++) cycle(tag);
    chk({tag, ".ack_lo"}, ack, 0);
  endtask

  int           p_stage;
  logic [W-1:0] p_val;
  int           r;

  initial begin
    // Reset token presented while reset is held.
    #12;
    model_reset();
    check_all("rst");
    chk("rst.token", data_out, 4'b0110);
    ack_in = 4'hF;
    @(negedge clk);
    rst_n = 1'b1;
    cycle("rst_tok");
    chk("rst_tok.null", data_out, 4'b0000);

    // Single word through an empty buffer.
    ack_in  = '0;
    data_in = dr(2'b10);
    cycle("single.cap");
    cycle("single.out");
    chk("single.dout", data_out, 4'b1001);
    chk("single.ack", ack, 1);
    data_in = '0;
    cycle("single.null");
    cycle("single.drop");
    chk("single.ack_lo", ack, 0);

    // Consumer join.
    ack_in = 4'b0111;
    repeat (5) cycle("join.hold");
    chk("join.held", data_out, 4'b1001);
    ack_in = 4'hF;
    cycle("join.all");
    chk("join.null", data_out, 4'b0000);
    push(2'b01, "join.push");
    ack_in = 4'b1000;
    repeat (3) cycle("join.mixed");
    chk("join.nopop_cnt", count, 1);
    chk("join.nopop_dout", data_out, 4'b0000);
    ack_in = '0;
    cycle("join.pop");
    chk("join.pop_dout", data_out, 4'b0110);
    ack_in = 4'hF;
    cycle("join.ret");

    // Full buffer back-pressure and pointer wrap.
    push(2'b11, "full.w1");
    push(2'b00, "full.w2");
    data_in = dr(2'b10);
    repeat (4) cycle("full.block");
    chk("full.ack_lo", ack, 0);
    chk("full.cnt", count, 2);
    ack_in = '0;
    cycle("full.pop");
    chk("full.pop_dout", data_out, 4'b1010);
    chk("full.no_refill", count, 1);
    cycle("full.refill");
    chk("full.refill_cnt", count, 2);
    push(2'b10, "full.w3");
    for (int i = 0; i < 24; i++) begin
      ack_in = (data_out != '0) ? 4'hF : 4'h0;
      cycle("full.drain");
    end
    chk("full.empty", count, 0);

    // Illegal code.
    ack_in  = 4'hF;
    cycle("ill.pre");
    data_in = 4'b0011;
    cycle("ill.set");
    chk("ill.err", err, 1);
    chk("ill.ack", ack, 0);
    chk("ill.cnt", count, 0);
    repeat (2) cycle("ill.hold");
    data_in = '0;
    cycle("ill.clear");
    push(2'b01, "ill.legal");
    chk("ill.sticky", err, 1);

    // Asynchronous reset mid-operation, producer still driving a word.
    ack_in = '0;
    cycle("mid.pop");
    ack_in = 4'b0111;
    push(2'b10, "mid.w1");
    data_in = dr(2'b11);
    for (int i = 0; i < 20 && ack !== 1'b1; i++) cycle("mid.w2");
    chk("mid.pre_cnt", count, 2);
    chk("mid.pre_ack", ack, 1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("mid.rst");
    chk("mid.rst_dout", data_out, 4'b0110);
    @(negedge clk);
    rst_n = 1'b1;
    cycle("mid.release");
    chk("mid.fresh_cnt", count, 1);

    // Random traffic.
    p_stage = 2;
    p_val   = 2'b11;
    for (int n = 0; n < 2500; n++) begin
      case (p_stage)
        0: if (ack == 1'b0 && $urandom_range(2) == 0) begin
             p_val = W'($urandom);
             if ($urandom_range(1) == 1) begin
               data_in = dr(p_val) & LOW_MASK;
               p_stage = 1;
             end else begin
               data_in = dr(p_val);
               p_stage = 2;
             end
           end
        1: begin
             data_in = dr(p_val);
             p_stage = 2;
           end
        default: if (ack == 1'b1) begin
             data_in = '0;
             p_stage = 0;
           end
      endcase
      r = $urandom_range(9);
      if (r < 4)      ack_in = 4'hF;
      else if (r < 8) ack_in = 4'h0;
      else            ack_in = N_ACK'($urandom);
      cycle("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
